// File: rtl/mmix_mem_bridge.sv
// MMIX load/store request to 32-bit Avalon-MM master bridge.
// Big-endian lane mapping; octa accesses split into two tetra beats.
module mmix_mem_bridge #(
    parameter int unsigned ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       mem_address,
    input  logic [1:0]        mem_datasize,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       mem_writedata,
    output logic [63:0]       mem_readdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    typedef enum logic [1:0] {StIdle, StCmd, StRdata, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              beat_q;
    logic              is_read_q;
    logic [63:0]       wdata_q;
    logic [31:0]       collect_q;

    logic [ADDR_W-1:0] req_addr;
    logic              last_beat;

    // Byte lanes enabled for an access of the given size at tetra offset k.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
        case (size)
            2'd0:    lane_be = 4'b1000 >> k;
            2'd1:    lane_be = k[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Place right-justified store data on its big-endian lanes for one beat.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] k,
                                               input logic beat, input logic [63:0] wd);
        case (size)
            2'd0:    lane_wdata = {24'd0, wd[7:0]} << {~k, 3'b000};
            2'd1:    lane_wdata = {16'd0, wd[15:0]} << {~k[1], 4'b0000};
            2'd2:    lane_wdata = wd[31:0];
            default: lane_wdata = beat ? wd[31:0] : wd[63:32];
        endcase
    endfunction

    // Pull the addressed lanes down to bit 0, zero-filled above the size.
    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] k,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        case (size)
            2'd0: begin
                sh         = rd >> {~k, 3'b000};
                lane_rdata = {24'd0, sh[7:0]};
            end
            2'd1: begin
                sh         = rd >> {~k[1], 4'b0000};
                lane_rdata = {16'd0, sh[15:0]};
            end
            default: lane_rdata = rd;
        endcase
    endfunction

    // Bus address for a beat: tetra aligned, beat 1 of an octa lands at A+4.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic beat);
        beat_addr = {a[ADDR_W-1:3], a[2] | beat, 2'b00};
    endfunction

    always_comb begin
        req_addr = mem_address[ADDR_W-1:0];
        case (mem_datasize)
            2'd1:    req_addr[0]   = 1'b0;
            2'd2:    req_addr[1:0] = 2'b00;
            2'd3:    req_addr[2:0] = 3'b000;
            default: req_addr[0]   = mem_address[0];
        endcase
    end

    assign last_beat = (size_q != 2'd3) || beat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            size_q         <= 2'd0;
            beat_q         <= 1'b0;
            is_read_q      <= 1'b0;
            wdata_q        <= 64'd0;
            collect_q      <= 32'd0;
            mem_readdata   <= 64'd0;
            mem_done       <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= 4'd0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'd0;
        end else begin
            mem_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        addr_q         <= req_addr;
                        size_q         <= mem_datasize;
                        beat_q         <= 1'b0;
                        is_read_q      <= mem_read;
                        wdata_q        <= mem_writedata;
                        avm_address    <= beat_addr(req_addr, 1'b0);
                        avm_byteenable <= lane_be(mem_datasize, req_addr[1:0]);
                        avm_read       <= mem_read;
                        avm_write      <= ~mem_read;
                        avm_writedata  <= mem_read ? 32'd0 :
                                          lane_wdata(mem_datasize, req_addr[1:0], 1'b0,
                                                     mem_writedata);
                        state_q        <= StCmd;
                    end
                end
                StCmd: begin
                    if (!avm_waitrequest) begin
                        if (is_read_q) begin
                            avm_read <= 1'b0;
                            state_q  <= StRdata;
                        end else if (last_beat) begin
                            avm_write <= 1'b0;
                            mem_done  <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            beat_q        <= 1'b1;
                            avm_address   <= beat_addr(addr_q, 1'b1);
                            avm_writedata <= lane_wdata(size_q, addr_q[1:0], 1'b1, wdata_q);
                        end
                    end
                end
                StRdata: begin
                    if (avm_readdatavalid) begin
                        if (last_beat) begin
                            mem_readdata <= (size_q == 2'd3) ? {collect_q, avm_readdata} :
                                            {32'd0, lane_rdata(size_q, addr_q[1:0],
                                                               avm_readdata)};
                            mem_done     <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            collect_q   <= avm_readdata;
                            beat_q      <= 1'b1;
                            avm_read    <= 1'b1;
                            avm_address <= beat_addr(addr_q, 1'b1);
                            state_q     <= StCmd;
                        end
                    end
                end
                // One recovery cycle so a request still held this cycle is not re-issued.
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Directed self-checking bench for mmix_mem_bridge with a small Avalon slave model.
module tb_mmix_mem_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] mem_address = 64'd0;
    logic [1:0]  mem_datasize = 2'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] mem_writedata = 64'd0;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic [22:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    int n_checks = 0;
    int n_fail = 0;

    // Slave model state
    logic        rdv = 1'b0;
    logic [31:0] rdata_q = 32'd0;
    logic        rdv_hold = 1'b0;
    logic        stray_rdv = 1'b0;
    int          stall_used = 0;
    int          stall_req = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_done = 0;
    logic [22:0] wr_addr [16];
    logic [3:0]  wr_be   [16];
    logic [31:0] wr_data [16];
    logic [22:0] rd_addr [16];
    logic [3:0]  rd_be   [16];
    logic [31:0] rd_src  [16];
    logic [22:0] st_addr [16];
    logic [31:0] st_data [16];

    mmix_mem_bridge #(.ADDR_W(23)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_address       (mem_address),
        .mem_datasize      (mem_datasize),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_done          (mem_done),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest   = (avm_read || avm_write) && (stall_used < stall_req);
    assign avm_readdatavalid = rdv | stray_rdv;
    assign avm_readdata      = stray_rdv ? 32'hFFFF_FFFF : rdata_q;

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (reset_n && (avm_read || avm_write)) begin
            if (avm_waitrequest) begin
                st_addr[stall_used[3:0]] <= avm_address;
                st_data[stall_used[3:0]] <= avm_writedata;
                stall_used <= stall_used + 1;
            end else if (avm_write) begin
                wr_addr[n_wr[3:0]] <= avm_address;
                wr_be[n_wr[3:0]]   <= avm_byteenable;
                wr_data[n_wr[3:0]] <= avm_writedata;
                n_wr <= n_wr + 1;
            end else begin
                rd_addr[n_rd[3:0]] <= avm_address;
                rd_be[n_rd[3:0]]   <= avm_byteenable;
                n_rd <= n_rd + 1;
                if (!rdv_hold) begin
                    rdv     <= 1'b1;
                    rdata_q <= rd_src[n_rd[3:0]];
                end
            end
        end
        if (reset_n && mem_done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in the current (IDLE) cycle; return cycles until mem_done is seen.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [1:0] size, input logic [63:0] wd, input logic hold,
                          output int cycles);
        mem_address   = addr;
        mem_datasize  = size;
        mem_writedata = wd;
        mem_read      = rd;
        mem_write     = wr;
        cycles = 0;
        while (!mem_done && cycles < 40) begin
            tick();
            cycles++;
        end
        check("done_seen", 64'(mem_done), 64'd1);
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        int c;
        int c2;
        int bw;
        int br;
        int bs;
        int bd;

        // Reset state
        tick();
        tick();
        check("rst_readdata", mem_readdata, 64'd0);
        check("rst_ctl", {59'd0, mem_done, avm_read, avm_write, 2'b00}, 64'd0);
        check("rst_bus", {5'd0, avm_address, avm_byteenable, avm_writedata}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 1: STB, upper address bits ignored
        bw = n_wr;
        do_req(1'b0, 1'b1, 64'hFFFF_0000_0000_1003, 2'd0, 64'hAB, 1'b0, c);
        check("t1_cycles", 64'(c), 64'd2);
        check("t1_readdata_unchanged", mem_readdata, 64'd0);
        tick();
        check("t1_done_pulse", 64'(mem_done), 64'd0);
        check("t1_nwr", 64'(n_wr - bw), 64'd1);
        check("t1_addr", 64'(wr_addr[bw[3:0]]), 64'h1000);
        check("t1_be", 64'(wr_be[bw[3:0]]), 64'h1);
        check("t1_data", 64'(wr_data[bw[3:0]] & 32'h0000_00FF), 64'hAB);

        // 2: LDW at odd address
        br = n_rd;
        rd_src[br[3:0]] = 32'h1122_3344;
        do_req(1'b1, 1'b0, 64'h2003, 2'd1, 64'd0, 1'b0, c);
        check("t2_cycles", 64'(c), 64'd3);
        check("t2_readdata", mem_readdata, 64'h3344);
        tick();
        check("t2_addr", 64'(rd_addr[br[3:0]]), 64'h2000);
        check("t2_be", 64'(rd_be[br[3:0]]), 64'h3);

        // 3: STO with two stall cycles on beat 0
        bw = n_wr;
        bs = stall_used;
        stall_req = stall_used + 2;
        do_req(1'b0, 1'b1, 64'h3005, 2'd3, 64'h0102_0304_0506_0708, 1'b0, c);
        check("t3_cycles", 64'(c), 64'd5);
        tick();
        check("t3_stall0_addr", 64'(st_addr[bs[3:0]]), 64'h3000);
        check("t3_stall1_addr", 64'(st_addr[4'(bs + 1)]), 64'h3000);
        check("t3_stall0_data", 64'(st_data[bs[3:0]]), 64'h0102_0304);
        check("t3_stall1_data", 64'(st_data[4'(bs + 1)]), 64'h0102_0304);
        check("t3_nwr", 64'(n_wr - bw), 64'd2);
        check("t3_b0_addr", 64'(wr_addr[bw[3:0]]), 64'h3000);
        check("t3_b0_data", 64'(wr_data[bw[3:0]]), 64'h0102_0304);
        check("t3_b0_be", 64'(wr_be[bw[3:0]]), 64'hF);
        check("t3_b1_addr", 64'(wr_addr[4'(bw + 1)]), 64'h3004);
        check("t3_b1_data", 64'(wr_data[4'(bw + 1)]), 64'h0506_0708);
        check("t3_b1_be", 64'(wr_be[4'(bw + 1)]), 64'hF);

        // 4: LDO
        br = n_rd;
        bd = n_done;
        rd_src[br[3:0]]      = 32'hDEAD_BEEF;
        rd_src[4'(br + 1)]   = 32'hCAFE_F00D;
        do_req(1'b1, 1'b0, 64'h4000, 2'd3, 64'd0, 1'b0, c);
        check("t4_cycles", 64'(c), 64'd5);
        check("t4_readdata", mem_readdata, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check("t4_done_pulse", 64'(mem_done), 64'd0);
        tick();
        check("t4_ndone", 64'(n_done - bd), 64'd1);
        check("t4_b1_addr", 64'(rd_addr[4'(br + 1)]), 64'h4004);

        // 5: CSWAP: read held through DONE, write requested in the following cycle
        br = n_rd;
        bw = n_wr;
        rd_src[br[3:0]] = 32'h0BAD_F00D;
        do_req(1'b1, 1'b0, 64'h5000, 2'd2, 64'd0, 1'b1, c);
        check("t5_rd_readdata", mem_readdata, 64'h0BAD_F00D);
        tick();
        check("t5_idle_no_read", 64'(avm_read), 64'd0);
        do_req(1'b0, 1'b1, 64'h5000, 2'd2, 64'hCAFE_BABE, 1'b0, c2);
        check("t5_wr_cycles", 64'(c2), 64'd2);
        tick();
        check("t5_nrd", 64'(n_rd - br), 64'd1);
        check("t5_nwr", 64'(n_wr - bw), 64'd1);
        check("t5_wr_data", 64'(wr_data[bw[3:0]]), 64'hCAFE_BABE);

        // 7: LDB at tetra offset 1
        br = n_rd;
        rd_src[br[3:0]] = 32'hA1B2_C3D4;
        do_req(1'b1, 1'b0, 64'h7001, 2'd0, 64'd0, 1'b0, c);
        check("t7_readdata", mem_readdata, 64'hB2);
        tick();
        check("t7_be", 64'(rd_be[br[3:0]]), 64'h4);
        check("t7_addr", 64'(rd_addr[br[3:0]]), 64'h7000);

        // 8: STW at offset 0, upper store data ignored
        bw = n_wr;
        do_req(1'b0, 1'b1, 64'h7000, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, c);
        check("t8_readdata_unchanged", mem_readdata, 64'hB2);
        tick();
        check("t8_be", 64'(wr_be[bw[3:0]]), 64'hC);
        check("t8_data", 64'(wr_data[bw[3:0]] & 32'hFFFF_0000), 64'hBEEF_0000);

        // 9: read and write together, read wins
        br = n_rd;
        bw = n_wr;
        rd_src[br[3:0]] = 32'h1357_9BDF;
        do_req(1'b1, 1'b1, 64'h8000, 2'd2, 64'h1111, 1'b0, c);
        check("t9_readdata", mem_readdata, 64'h1357_9BDF);
        tick();
        check("t9_nrd", 64'(n_rd - br), 64'd1);
        check("t9_nwr", 64'(n_wr - bw), 64'd0);

        // 6: reset while waiting for read data, then stray readdatavalid
        rdv_hold     = 1'b1;
        bd           = n_done;
        mem_address  = 64'h6000;
        mem_datasize = 2'd2;
        mem_read     = 1'b1;
        tick();
        tick();
        check("t6_rdata_avm_read", 64'(avm_read), 64'd0);
        #2;
        reset_n  = 1'b0;
        #1;
        mem_read = 1'b0;
        check("t6_rst_readdata", mem_readdata, 64'd0);
        check("t6_rst_bus", {5'd0, avm_address, avm_byteenable, avm_writedata}, 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        stray_rdv = 1'b1;
        tick();
        tick();
        tick();
        stray_rdv = 1'b0;
        rdv_hold  = 1'b0;
        tick();
        check("t6_no_done", 64'(n_done - bd), 64'd0);
        check("t6_readdata", mem_readdata, 64'd0);
        check("t6_ctl", {59'd0, mem_done, avm_read, avm_write, 2'b00}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
